// File: rtl/uart_rx_keys.sv
// rtl/uart_rx_keys.sv - UART 8N1 receiver decoding key bytes into one-hot button pulses
//
// Purpose: receives 8N1 frames on rx and turns the ASCII keys a/d/w/s
// (either case) into the same one-hot button pulses the board push-buttons
// produce. The last good byte is kept on rx_data for debug.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial input, idle high, asynchronous to clk
//   rx_data    last correctly framed byte, held until the next good frame
//   rx_valid   one-cycle pulse, rx_data updated in the same cycle
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   button     one-hot command pulse coincident with rx_valid
//   busy       high whenever the receiver is not idle (including WAIT_HIGH)

module uart_rx_keys #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [3:0] button,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  // In WAIT_HIGH the counter first runs up to ARMED so the two synchronizer
  // flops hold real line samples instead of their reset value of 1.
  localparam logic [CW-1:0] ARMED   = CW'(2);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          rx_meta, rxs;
  logic          good, bad;

  function automatic logic [3:0] decode(input logic [7:0] b);
    // OR-ing 0x20 folds upper case onto lower case; only 0x41/0x61 map to
    // 'a' (and likewise for d/w/s), so no other byte aliases a key.
    case (b | 8'h20)
      8'h61:   decode = 4'b0001;
      8'h64:   decode = 4'b1000;
      8'h77:   decode = 4'b0100;
      8'h73:   decode = 4'b0010;
      default: decode = 4'b0000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_HIGH;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    good    = 1'b0;
    bad     = 1'b0;
    case (state)
      WAIT_HIGH: begin
        if (cnt != ARMED) cnt_n = cnt + CW'(1);
        else if (rxs)     state_n = IDLE;
      end
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          shreg_n = {rxs, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          if (rxs) begin
            good    = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            // Break/garbled line: wait for it to return high so a held-low
            // line reports only one error.
            bad     = 1'b1;
            state_n = WAIT_HIGH;
            cnt_n   = ARMED;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      button    <= 4'b0000;
    end else begin
      rx_valid  <= good;
      frame_err <= bad;
      button    <= good ? decode(shreg) : 4'b0000;
      if (good) rx_data <= shreg;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_keys.md
# uart_rx_keys

UART 8N1 receiver that turns a serial keyboard/host stream into the same 4-bit one-hot button pulses the board push-buttons produce. Incoming bytes are decoded into shift-left, shift-right and the two toggle/rotate commands. The block sits between the FPGA RX pin and the game/LED control logic as a second, remote source of `button` events. It also exposes the raw received byte for debug.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud): clock cycles per bit; legal range >= 4; counter width `$clog2(CLKS_PER_BIT)`.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial input, asynchronous to `clk`, idle high.
- `rx_data`  out  8  last correctly framed byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` updated in the same cycle.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `button`  out  4  one-cycle one-hot command pulse, coincident with `rx_valid`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. Only the synchronized line `rxs` is used internally.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
- Arming:
  - After reset and after any framing error, the FSM is in WAIT_HIGH.
  - WAIT_HIGH -> IDLE on the first cycle `rxs`=1.
- IDLE -> START when `rxs`=0. That cycle is "cycle 0". The bit counter and bit index clear.
- START: check `rxs` CLKS_PER_BIT/2 cycles after cycle 0 (integer divide).
  - `rxs`=0: go to DATA with the counter cleared.
  - `rxs`=1: glitch; return to IDLE. No outputs change.
- DATA: sample `rxs` every CLKS_PER_BIT cycles. Bits shift LSB first into the shift register. After the 8th sample, go to STOP.
- STOP: sample `rxs` CLKS_PER_BIT cycles after bit 7.
  - `rxs`=1: register the outputs (below) and go directly to IDLE. The next frame's start may begin on the following cycle; no extra idle bit is required.
  - `rxs`=0: pulse `frame_err`, leave `rx_data` unchanged, no `rx_valid`, no `button`. Go to WAIT_HIGH, so a held-low break line produces exactly one `frame_err`.
- Good-frame outputs: `rx_data`<=byte, `rx_valid` pulses, `button` is decoded from the byte.
- Button decode (case-insensitive, ASCII):
  - 'a'/'A' (0x61/0x41) -> 4'b0001, shift left.
  - 'd'/'D' (0x64/0x44) -> 4'b1000, shift right.
  - 'w'/'W' (0x77/0x57) -> 4'b0100, toggle.
  - 's'/'S' (0x73/0x53) -> 4'b0010, toggle.
  - Any other byte -> 4'b0000; `rx_valid` still pulses.
- `button` is never more than one-hot and is never asserted without `rx_valid`.
- `busy` = (state != IDLE). This includes WAIT_HIGH.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `button`=4'b0000, `busy`=1 (WAIT_HIGH), synchronizer=2'b11, counters=0.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - The partial byte is discarded.
  - After release, a line still low is ignored until it goes high.
- Pin to `rxs` latency: 2 cycles.
- Sample points relative to cycle 0, with H=CLKS_PER_BIT/2 and N=CLKS_PER_BIT:
  - start at H;
  - data bit k at H+(k+1)*N;
  - stop at H+9*N.
- `rx_valid`/`button`/`frame_err` are registered and asserted in cycle H+9*N+1, for exactly 1 cycle.
- `busy` drops in the same cycle `rx_valid` rises, for a good frame.
- Glitch rejection: a low pulse shorter than H cycles on `rxs` is never accepted as a start.

## Test plan
All scenarios use CLKS_PER_BIT=16 (H=8, N=16). Drive 8N1 frames on `rx` at 16 cycles/bit.
- Send 0x61 'a' -> `rx_valid` and `button`=4'b0001 for exactly 1 cycle, at cycle 153 after cycle 0; `rx_data`=0x61 and held afterwards.
- Send 'D', 'w', 'S' back-to-back with no idle gap -> three `rx_valid` pulses, with `button` = 1000, 0100, 0010 in order; `rx_data` ends at 0x53.
- Send 0x55 -> `rx_valid`=1, `rx_data`=0x55, `button`=0000, `frame_err`=0.
- Drive a 4-cycle low glitch, then hold `rx` high for 200 cycles -> no `rx_valid`/`frame_err`; `busy` returns to 0 by cycle 9 after cycle 0.
- Frame 0x00 with stop bit low, then hold the line low for 300 cycles -> one `frame_err` pulse, no `rx_valid`, `rx_data` unchanged, `busy`=1. Then release high and send 'a' -> `button`=0001.
- Assert `rst` during data bit 3 of a frame while `rx` is low, keep `rx` low for 20 cycles after release -> outputs at reset values, no frame accepted; the next complete 'w' frame gives `button`=0100.
